// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: bubble encoding, fetch defaults, fetch FSM
// states and the IF/ID register layout.
package riscv_pipe_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  // Field order matters: it is also the layout held by the skid entry.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
    logic                valid;
  } if_id_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid register that keeps the fetch response arriving on the
// cycle a stall begins, so that release needs no re-fetch bubble.
module if_skid_buf
  import riscv_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  if_id_entry_t entry_in,
  output if_id_entry_t entry_out
);

  if_id_entry_t entry_q;

  // Capture on load; clear only drops the valid bit (payload is don't-care).
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else if (clear) begin
      entry_q.valid <= 1'b0;
    end else if (load) begin
      entry_q <= entry_in;
    end
  end

  assign entry_out = entry_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage controller: owns the fetch PC, drives a
// synchronous-read instruction memory and produces the IF/ID register.
// Per-edge priority is rst > redirect > stall > advance; flush only
// replaces what is written into IF/ID with a bubble.
module if_stage_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF,
  parameter logic [31:0]      NOP      = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            req_valid_q;
  fetch_state_e    state;
  if_id_entry_t    if_id_q;

  if_id_entry_t    bubble_entry;
  if_id_entry_t    fetch_entry;
  if_id_entry_t    skid_entry;
  logic            skid_load;
  logic            skid_clear;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;

  assign bubble_entry    = '{pc: '0, instr: NOP, valid: 1'b0};
  // Response on imem_rdata belongs to the address issued one cycle ago.
  assign fetch_entry     = '{pc: req_pc_q, instr: imem_rdata, valid: req_valid_q};
  assign pc_plus4        = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // The skid is filled on the first stalled edge only; later responses
  // during HOLD are re-reads of pc_q and are dropped.
  assign skid_load  = !redirect_valid && (state == RUN) && stall;
  assign skid_clear = redirect_valid || ((state == HOLD) && (!stall || flush));

  if_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .entry_in  (fetch_entry),
    .entry_out (skid_entry)
  );

  // Fetch PC, outstanding-request tracking, RUN/HOLD FSM and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      state       <= RUN;
      if_id_q     <= bubble_entry;
    end else if (redirect_valid) begin
      pc_q        <= redirect_target;
      req_valid_q <= 1'b0;
      state       <= RUN;
      if_id_q     <= bubble_entry;
    end else begin
      case (state)
        RUN: begin
          if (stall) begin
            state <= HOLD;
            if (flush) if_id_q <= bubble_entry;
          end else begin
            if_id_q     <= flush ? bubble_entry : fetch_entry;
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
            pc_q        <= pc_plus4;
          end
        end
        HOLD: begin
          if (stall) begin
            if (flush) if_id_q <= bubble_entry;
          end else begin
            if_id_q     <= flush ? bubble_entry : skid_entry;
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
            pc_q        <= pc_plus4;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Randomised scoreboard bench for if_stage_ctrl. The reference model views
// the fetch path as a one-deep stream of pending fetches between the PC
// generator and IF/ID that simply freezes while stalled.
module tb_if_stage_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOPW   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
  );

  // Address-tagged synchronous memory: every word identifies its address.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC3C3_0001;
  endfunction

  always @(posedge clk) imem_rdata <= tag(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        exact;  // bubble with defined pc/instr contents
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [31:0] m_pc;       // next address to fetch
  logic [31:0] f_pc;       // pending fetch awaiting IF/ID
  logic        f_valid;
  logic        m_held;     // previous edge was already stalled
  exp_t        m_ifid;

  task automatic model_step(input logic r, st, fl, rv, input logic [31:0] rp);
    exp_t bub;
    bub = '{pc: 32'h0, instr: NOPW, valid: 1'b0, exact: 1'b1, addr: 32'h0};
    if (r) begin
      m_pc = RST_PC; f_valid = 1'b0; f_pc = 32'h0; m_held = 1'b0; m_ifid = bub;
    end else if (rv) begin
      m_pc = rp & 32'hFFFF_FFFC; f_valid = 1'b0; m_held = 1'b0; m_ifid = bub;
    end else if (st) begin
      if (fl) begin
        m_ifid = bub;
        if (m_held) f_valid = 1'b0;
      end
      m_held = 1'b1;
    end else begin
      if (fl) m_ifid = bub;
      else m_ifid = '{pc: f_pc, instr: tag(f_pc), valid: f_valid, exact: 1'b0, addr: 32'h0};
      f_pc = m_pc; f_valid = 1'b1; m_pc = m_pc + 32'd4; m_held = 1'b0;
    end
    m_ifid.addr = m_pc;
  endtask

  task automatic cyc(input logic r, st, fl, rv, input logic [31:0] rp);
    @(negedge clk);
    rst = r; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rp;
    model_step(r, st, fl, rv, rp);
    exp_q.push_back(m_ifid);
  endtask

  // Monitor: one IF/ID transaction per edge, compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("t=%0t ifid pc=%h instr=%h valid=%b addr=%h | exp pc=%h valid=%b addr=%h",
                 $time, if_id_pc, if_id_instr, if_id_valid, imem_addr, e.pc, e.valid, e.addr);
        checks++;
        if (if_id_valid !== e.valid) begin
          errors++;
          $display("FAIL valid: got %b expected %b", if_id_valid, e.valid);
        end
        checks++;
        if (imem_addr !== e.addr) begin
          errors++;
          $display("FAIL imem_addr: got %h expected %h", imem_addr, e.addr);
        end
        if (e.valid || e.exact) begin
          checks++;
          if (if_id_pc !== e.pc) begin
            errors++;
            $display("FAIL if_id_pc: got %h expected %h", if_id_pc, e.pc);
          end
          checks++;
          if (if_id_instr !== e.instr) begin
            errors++;
            $display("FAIL if_id_instr: got %h expected %h", if_id_instr, e.instr);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and release: IF/ID reaches 0x00400008 on the 4th free edge.
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);                     // single-cycle stall
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);          // 3-cycle stall
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);          // enter HOLD, then redirect
    cyc(0, 1, 0, 1, 32'h0040_0100);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);                     // flush while advancing
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);          // flush inside HOLD
    cyc(0, 1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h0000_0000);         // stall right after redirect
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFE);         // wrap-around fetch
    repeat (4) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);          // reset in the middle of HOLD
    cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      logic        r, st, fl, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) < 2);
      rv = ($urandom_range(0, 99) < 6);
      st = ($urandom_range(0, 99) < 35);
      fl = ($urandom_range(0, 99) < 10);
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      cyc(r, st, fl, rv, rp);
    end

    @(negedge clk);
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage_ctrl.md
# if_stage_ctrl

Instruction-fetch stage controller that consumes the hazard unit's `stall` and `flush` decisions and the branch-redirect from EX. Owns the fetch PC, drives a synchronous-read instruction memory, and produces the IF/ID pipeline register. A one-entry skid buffer gives zero-bubble stall release despite the one-cycle memory latency.

## Interface
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0040_0000, first fetch address after reset
- `NOP`, 32'h0000_0013, instruction word inserted as a bubble (`addi x0,x0,0`)

Ports:
- `clk` in 1, single clock; all state updates on posedge
- `rst` in 1, synchronous, active-high reset
- `stall` in 1, hazard-unit hold request (level, sampled at posedge)
- `flush` in 1, squash the instruction entering IF/ID at this edge
- `redirect_valid` in 1, branch/jump taken in EX
- `redirect_pc` in XLEN, redirect target; bits [1:0] forced to 0 internally
- `imem_addr` out XLEN, fetch address; equals `pc_q`, driven straight from the register
- `imem_rdata` in 32, data for the address presented in the previous cycle
- `if_id_pc` out XLEN, PC of the instruction in IF/ID
- `if_id_instr` out 32, instruction in IF/ID
- `if_id_valid` out 1, IF/ID holds a real instruction

## Operation
- Internal state:
  - `pc_q`: next address to fetch.
  - `req_pc_q`, `req_valid_q`: identify the response currently on `imem_rdata`.
  - Skid entry: `{pc, instr, valid}`.
  - FSM `state`: RUN or HOLD.
- Priority per edge: `rst` > `redirect_valid` > `stall` > advance. `flush` then overrides only what is written into IF/ID.
- **rst:**
  - `pc_q`=RESET_PC, `req_valid_q`=0, skid valid=0, state=RUN.
  - `if_id_pc`=0, `if_id_instr`=NOP, `if_id_valid`=0.
- **redirect:**
  - `pc_q`<=`redirect_pc`, `req_valid_q`<=0, skid valid<=0.
  - IF/ID<=bubble (pc 0, NOP, valid 0). State<=RUN.
  - Applies from RUN or HOLD, with or without `stall`.
- **RUN, stall=0 (advance):**
  - IF/ID<={`req_pc_q`, `imem_rdata`, `req_valid_q`}.
  - `req_pc_q`<=`pc_q`, `req_valid_q`<=1, `pc_q`<=`pc_q`+4.
- **RUN, stall=1 (enter HOLD):**
  - skid<={`req_pc_q`, `imem_rdata`, `req_valid_q`}.
  - IF/ID, `pc_q`, `req_*` unchanged. State<=HOLD.
- **HOLD, stall=1:** everything holds. The response arriving is a re-read of `pc_q` and is ignored.
- **HOLD, stall=0 (release):**
  - IF/ID<=skid.
  - `req_pc_q`<=`pc_q`, `req_valid_q`<=1, `pc_q`<=`pc_q`+4.
  - Skid valid<=0. State<=RUN.
- **flush=1 (no redirect):**
  - The value written into IF/ID at that edge is replaced by a bubble. PC, req and FSM follow the rules above.
  - In HOLD, the skid is invalidated too.
  - With `stall`=1, IF/ID is still overwritten with a bubble.
- PC arithmetic: modulo 2^XLEN; `pc_q`+4 wraps from 32'hFFFF_FFFC to 0.

## Timing
- `imem_addr` is registered (no combinational path from `stall`/`flush`/`redirect`).
- Fetch-to-IF/ID latency: 2 edges. An address issued in cycle n reaches IF/ID at the end of cycle n+1.
- First valid instruction after reset deasserts: RESET_PC appears in IF/ID after the 2nd posedge with `rst`=0.
- Redirect penalty: 2 bubbles. The target is valid in IF/ID at the 2nd edge after the redirect edge.
- Stall of k cycles adds exactly k cycles; release causes no extra bubble.
- Stall entered while `req_valid_q`=0 (e.g. right after redirect): the skid captures invalid, and release writes a bubble.
- `if_id_*` are pure registers. Reset values are as listed under rst.

## Structure
- Shared package `riscv_pipe_pkg`: `NOP` constant, `RESET_PC` default, fetch FSM enum {RUN, HOLD}, IF/ID entry struct {pc, instr, valid}.
- Sub-module `if_skid_buf`: one-entry capture/invalidate register with `load`, `clear`, and `entry_out`. The rest of the logic stays in `if_stage_ctrl`.

## Test plan
- **Reset release:** `imem` returns addr-tagged words.
  - `imem_addr` sequence: 0x00400000, 0x00400004, ...
  - `if_id_valid` first rises with pc 0x00400000 at edge 2.
- **Single-cycle stall with IF/ID at 0x00400008:**
  - IF/ID holds 0x00400008 for one extra cycle.
  - It then shows 0x0040000C, 0x00400010 with no gap or duplicate.
- **3-cycle stall:**
  - IF/ID is held for 3 cycles.
  - The skid instruction (0x0040000C) appears on release.
  - `imem_addr` is constant during HOLD.
- **Redirect to 0x00400100 during HOLD:**
  - Two bubbles (`if_id_valid`=0), then pc 0x00400100.
  - The skid content is never emitted.
- **flush=1 with stall=0 while fetching 0x00400010:**
  - IF/ID gets valid=0 and NOP for that edge.
  - The next edge shows 0x00400014.
- **Edge cases:**
  - `redirect_pc`=0xFFFFFFFE: fetches 0xFFFFFFFC, then wraps to 0x00000000.
  - `rst` asserted mid-HOLD: all outputs return to their reset values at the next edge.
